// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int RD_LATENCY_MAX = 7;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational winner select between IF and LSU requests.
// MEM_ARB_RR_EN: round-robin on ties; otherwise LSU always beats IF.
module mem_arb_grant
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_state,
    input  logic       i_if_valid,
    input  logic       i_ls_valid,
`ifdef MEM_ARB_RR_EN
    input  logic       i_rr_ptr,
`endif
    output logic       o_grant_if,
    output logic       o_grant_ls
);

    logic w_idle;

    assign w_idle = (i_state == 2'(IDLE));

`ifdef MEM_ARB_RR_EN
    // i_rr_ptr holds the last granted owner; the other side wins a tie.
    assign o_grant_ls = w_idle & i_ls_valid & (~i_if_valid | (i_rr_ptr == OWN_IF));
    assign o_grant_if = w_idle & i_if_valid & (~i_ls_valid | (i_rr_ptr == OWN_LS));
`else
    assign o_grant_ls = w_idle & i_ls_valid;
    assign o_grant_if = w_idle & i_if_valid & ~i_ls_valid;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IF read-only, LSU read/write) arbiter onto a single-ported memory.
// Optional MEM_ARB_RR_EN macro selects round-robin tie-breaking instead of LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    // Handshake: a request transfers on a rising edge where valid and ready are both 1;
    // ready is only raised in IDLE for the winner, and requesters hold payload until then.
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic              ls_we,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int              CNT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_owner;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              w_grant_if;
    logic              w_grant_ls;
    logic              w_accept;
    logic              w_wait_done;

`ifdef MEM_ARB_RR_EN
    logic r_rr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= OWN_IF;
        end else if (w_accept) begin
            r_rr_ptr <= w_grant_ls;
        end
    end
`endif

    mem_arb_grant u_grant (
        .i_state    (r_state),
        .i_if_valid (if_req_valid),
        .i_ls_valid (ls_req_valid),
`ifdef MEM_ARB_RR_EN
        .i_rr_ptr   (r_rr_ptr),
`endif
        .o_grant_if (w_grant_if),
        .o_grant_ls (w_grant_ls)
    );

    assign w_accept    = w_grant_if | w_grant_ls;
    assign w_wait_done = (r_state == WAIT) && (r_cnt == CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ACCESS;
            ACCESS:  w_next = r_we ? RESP : WAIT;
            WAIT:    if (w_wait_done) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_owner    <= OWN_IF;
            r_cnt      <= '0;
            r_if_rdata <= '0;
            r_ls_rdata <= '0;
        end else begin
            // IF has no write path, so its grant latches zero write data.
            if (w_accept) begin
                r_addr  <= w_grant_ls ? ls_addr : if_addr;
                r_wdata <= w_grant_ls ? ls_wdata : '0;
                r_we    <= w_grant_ls & ls_we;
                r_owner <= w_grant_ls;
            end
            if (r_state == WAIT) begin
                if (w_wait_done) begin
                    r_cnt <= '0;
                    if (r_owner == OWN_LS) begin
                        r_ls_rdata <= mem_rdata;
                    end else begin
                        r_if_rdata <= mem_rdata;
                    end
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign if_req_ready = w_grant_if;
    assign ls_req_ready = w_grant_ls;
    assign mem_en       = (r_state == ACCESS);
    assign mem_we       = (r_state == ACCESS) & r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign if_rsp_valid = (r_state == RESP) & (r_owner == OWN_IF);
    assign ls_rsp_valid = (r_state == RESP) & (r_owner == OWN_LS);
    assign if_rdata     = r_if_rdata;
    assign ls_rdata     = r_ls_rdata;
    assign busy         = (r_state != IDLE);
    assign owner        = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LATENCY 1 and 3) against a latency-accurate memory model.
module tb_mem_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic clk;
  logic rst [2];
  logic if_req_valid [2];
  logic if_req_ready [2];
  logic [31:0] if_addr [2];
  logic if_rsp_valid [2];
  logic [31:0] if_rdata [2];
  logic ls_req_valid [2];
  logic ls_req_ready [2];
  logic [31:0] ls_addr [2];
  logic [31:0] ls_wdata [2];
  logic ls_we [2];
  logic ls_rsp_valid [2];
  logic [31:0] ls_rdata [2];
  logic mem_en [2];
  logic mem_we [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic busy [2];
  logic owner [2];

  int checks = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) dut0 (
    .clk(clk), .rst(rst[0]),
    .if_req_valid(if_req_valid[0]), .if_req_ready(if_req_ready[0]), .if_addr(if_addr[0]),
    .if_rsp_valid(if_rsp_valid[0]), .if_rdata(if_rdata[0]),
    .ls_req_valid(ls_req_valid[0]), .ls_req_ready(ls_req_ready[0]), .ls_addr(ls_addr[0]),
    .ls_wdata(ls_wdata[0]), .ls_we(ls_we[0]), .ls_rsp_valid(ls_rsp_valid[0]), .ls_rdata(ls_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .owner(owner[0])
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) dut1 (
    .clk(clk), .rst(rst[1]),
    .if_req_valid(if_req_valid[1]), .if_req_ready(if_req_ready[1]), .if_addr(if_addr[1]),
    .if_rsp_valid(if_rsp_valid[1]), .if_rdata(if_rdata[1]),
    .ls_req_valid(ls_req_valid[1]), .ls_req_ready(ls_req_ready[1]), .ls_addr(ls_addr[1]),
    .ls_wdata(ls_wdata[1]), .ls_we(ls_we[1]), .ls_rsp_valid(ls_rsp_valid[1]), .ls_rdata(ls_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .owner(owner[1])
  );

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // ---------------- memory model ----------------
  // Read data is valid only during the single cycle RD_LATENCY cycles after the strobe.
  logic [31:0] mem0 [logic [31:0]];
  logic [31:0] mem1 [logic [31:0]];
  logic        pv [2][3];
  logic [31:0] pd [2][3];

  function automatic logic [31:0] mem_rd(input int k, input logic [31:0] a);
    if (k == 0) return mem0.exists(a) ? mem0[a] : ~a;
    return mem1.exists(a) ? mem1[a] : ~a;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pv[k][2] <= pv[k][1];
      pv[k][1] <= pv[k][0];
      pd[k][2] <= pd[k][1];
      pd[k][1] <= pd[k][0];
      pv[k][0] <= mem_en[k] && !mem_we[k];
      pd[k][0] <= mem_rd(k, mem_addr[k]);
      if (mem_en[k] && mem_we[k]) begin
        if (k == 0) mem0[mem_addr[k]] = mem_wdata[k];
        else mem1[mem_addr[k]] = mem_wdata[k];
      end
    end
  end

  assign mem_rdata[0] = pv[0][0] ? pd[0][0] : JUNK;
  assign mem_rdata[1] = pv[1][2] ? pd[1][2] : JUNK;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      if_req_valid[k] = 1'b0; if_addr[k] = '0;
      ls_req_valid[k] = 1'b0; ls_addr[k] = '0; ls_wdata[k] = '0; ls_we[k] = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_txn(input int k, input bit is_ls, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int dly, output logic [31:0] rd);
    bit got;
    logic [31:0] prev_ls;
    logic own_rsp, oth_rsp;
    prev_ls = ls_rdata[k];
    dly = -1;
    rd = '0;
    @(posedge clk); #1;
    if (is_ls) begin
      ls_req_valid[k] = 1'b1; ls_addr[k] = addr; ls_wdata[k] = wdata; ls_we[k] = we;
    end else begin
      if_req_valid[k] = 1'b1; if_addr[k] = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = is_ls ? ls_req_ready[k] : if_req_ready[k];
    end
    chk($sformatf("txn_accept%0d", k), 64'(got), 64'd1);
    @(posedge clk); #1;
    if_req_valid[k] = 1'b0;
    ls_req_valid[k] = 1'b0;
    if (!got) return;
    @(negedge clk);
    chk($sformatf("txn_strobe%0d", k), {62'd0, mem_en[k], mem_we[k]}, {62'd0, 1'b1, we});
    chk($sformatf("txn_addr%0d", k), 64'(mem_addr[k]), 64'(addr));
    chk($sformatf("txn_wdata%0d", k), 64'(mem_wdata[k]), is_ls ? 64'(wdata) : 64'd0);
    chk($sformatf("txn_busy_owner%0d", k), {62'd0, busy[k], owner[k]}, {62'd0, 1'b1, is_ls});
    for (int d = 2; d <= 12 && dly < 0; d++) begin
      @(negedge clk);
      own_rsp = is_ls ? ls_rsp_valid[k] : if_rsp_valid[k];
      oth_rsp = is_ls ? if_rsp_valid[k] : ls_rsp_valid[k];
      chk($sformatf("txn_no_cross%0d", k), 64'(oth_rsp), 64'd0);
      chk($sformatf("txn_no_strobe%0d", k), 64'(mem_en[k]), 64'd0);
      if (own_rsp) begin
        dly = d;
        rd = is_ls ? ls_rdata[k] : if_rdata[k];
      end
    end
    @(negedge clk);
    own_rsp = is_ls ? ls_rsp_valid[k] : if_rsp_valid[k];
    chk($sformatf("txn_single_pulse%0d", k), {62'd0, own_rsp, busy[k]}, 64'd0);
    if (is_ls && we) chk($sformatf("txn_wr_rdata_hold%0d", k), 64'(ls_rdata[k]), 64'(prev_ls));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
  endtask

  // ---------------- reference model for random traffic ----------------
  int cyc;
  int nf [2];
  int tacc [2];
  int rsp_c [2];
  bit ow_m [2];
  bit we_m [2];
  bit last_g [2];
  bit acc_if [2];
  bit acc_ls [2];
  logic [31:0] addr_m [2];
  logic [31:0] wdata_m [2];
  logic [31:0] rd_exp [2];
  logic [31:0] if_rd_m [2];
  logic [31:0] ls_rd_m [2];

  task automatic model_init();
    for (int k = 0; k < 2; k++) begin
      nf[k] = cyc; tacc[k] = -100; rsp_c[k] = -100;
      ow_m[k] = 0; we_m[k] = 0; last_g[k] = 0; acc_if[k] = 0; acc_ls[k] = 0;
      addr_m[k] = '0; wdata_m[k] = '0; rd_exp[k] = '0; if_rd_m[k] = '0; ls_rd_m[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    bit idle, iv, lv, wi, wl, en_e, rsp_e;
    idle = (cyc >= nf[k]);
    iv = if_req_valid[k];
    lv = ls_req_valid[k];
    wl = idle && lv;
    wi = idle && iv && !lv;
`ifdef MEM_ARB_RR_EN
    if (idle && iv && lv) begin
      wl = !last_g[k];
      wi = last_g[k];
    end
`endif
    chk($sformatf("rnd_ready%0d", k), {62'd0, if_req_ready[k], ls_req_ready[k]}, {62'd0, wi, wl});
    chk($sformatf("rnd_busy%0d", k), 64'(busy[k]), 64'(!idle));
    en_e = !idle && (cyc == tacc[k] + 1);
    chk($sformatf("rnd_strobe%0d", k), {62'd0, mem_en[k], mem_we[k]}, {62'd0, en_e, en_e && we_m[k]});
    chk($sformatf("rnd_maddr%0d", k), 64'(mem_addr[k]), 64'(addr_m[k]));
    chk($sformatf("rnd_mwdata%0d", k), 64'(mem_wdata[k]), 64'(wdata_m[k]));
    rsp_e = !idle && (cyc == rsp_c[k]);
    if (rsp_e && !we_m[k]) begin
      if (ow_m[k]) ls_rd_m[k] = rd_exp[k];
      else if_rd_m[k] = rd_exp[k];
    end
    chk($sformatf("rnd_rsp%0d", k), {62'd0, if_rsp_valid[k], ls_rsp_valid[k]},
        {62'd0, rsp_e && !ow_m[k], rsp_e && ow_m[k]});
    chk($sformatf("rnd_if_rdata%0d", k), 64'(if_rdata[k]), 64'(if_rd_m[k]));
    chk($sformatf("rnd_ls_rdata%0d", k), 64'(ls_rdata[k]), 64'(ls_rd_m[k]));
    chk($sformatf("rnd_owner%0d", k), 64'(owner[k]), 64'(ow_m[k]));
    acc_if[k] = wi;
    acc_ls[k] = wl;
    if (wi || wl) begin
      tacc[k] = cyc;
      ow_m[k] = wl;
      we_m[k] = wl && ls_we[k];
      addr_m[k] = wl ? ls_addr[k] : if_addr[k];
      wdata_m[k] = wl ? ls_wdata[k] : 32'd0;
      rd_exp[k] = mem_rd(k, addr_m[k]);
      rsp_c[k] = cyc + (we_m[k] ? 2 : 2 + lat(k));
      nf[k] = cyc + (we_m[k] ? 3 : 3 + lat(k));
      last_g[k] = wl;
    end
  endtask

  task automatic rand_drive(input int k);
    if (!if_req_valid[k] || acc_if[k]) begin
      if_req_valid[k] = ($urandom_range(0, 3) != 0);
      if_addr[k] = 32'($urandom_range(0, 15)) << 2;
    end else if ($urandom_range(0, 15) == 0) begin
      if_req_valid[k] = 1'b0;
    end
    if (!ls_req_valid[k] || acc_ls[k]) begin
      ls_req_valid[k] = ($urandom_range(0, 3) != 0);
      ls_addr[k] = 32'($urandom_range(0, 15)) << 2;
      ls_we[k] = 1'($urandom_range(0, 1));
      ls_wdata[k] = $urandom;
    end else if ($urandom_range(0, 15) == 0) begin
      ls_req_valid[k] = 1'b0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          k;
    bit          is_ls;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_dly;
  } vec_t;

  vec_t vt [8];

  // ---------------- main test ----------------
  initial begin
    int dly;
    int grants;
    int last_t;
    int n_if;
    int n_ls;
    bit gi;
    bit gl;
    logic [31:0] rd;
    logic [0:0] exp_q [$];

    vt[0] = '{0, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 2};
    vt[1] = '{0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3};
    vt[2] = '{0, 1'b1, 1'b1, 32'hFFFF_0000, 32'h1234_5678, 32'h0, 2};
    vt[3] = '{0, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0, 32'h1234_5678, 3};
    vt[4] = '{0, 1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'hFFFF_FCFF, 3};
    vt[5] = '{1, 1'b1, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 2};
    vt[6] = '{1, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 5};
    vt[7] = '{1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 5};

    clear_inputs();
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_flags%0d", k),
          {56'd0, if_req_ready[k], ls_req_ready[k], if_rsp_valid[k], ls_rsp_valid[k],
           mem_en[k], mem_we[k], busy[k], owner[k]}, 64'd0);
      chk($sformatf("reset_rdata%0d", k), {if_rdata[k], ls_rdata[k]}, 64'd0);
      chk($sformatf("reset_mem_bus%0d", k), {mem_addr[k], mem_wdata[k]}, 64'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_txn(vt[i].k, vt[i].is_ls, vt[i].we, vt[i].addr, vt[i].wdata, dly, rd);
      chk($sformatf("vec%0d_latency", i), 64'(dly), 64'(vt[i].exp_dly));
      if (!vt[i].we) chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vt[i].exp_rd));
    end

    // Both requesters valid continuously, four reads each, on the latency-1 instance.
`ifdef MEM_ARB_RR_EN
    for (int i = 0; i < 4; i++) begin exp_q.push_back(1'b1); exp_q.push_back(1'b0); end
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
`endif
    pulse_reset();
    @(posedge clk); #1;
    if_req_valid[0] = 1'b1; if_addr[0] = 32'h0000_1000;
    ls_req_valid[0] = 1'b1; ls_addr[0] = 32'h0000_2000; ls_we[0] = 1'b0;
    grants = 0; last_t = -1; n_if = 0; n_ls = 0;
    for (int i = 0; i < 100 && grants < 8; i++) begin
      @(negedge clk);
      gi = if_req_ready[0] && if_req_valid[0];
      gl = ls_req_ready[0] && ls_req_valid[0];
      chk("grant_exclusive", 64'(gi && gl), 64'd0);
      if (gi || gl) begin
        chk($sformatf("grant_order%0d", grants), 64'(gl), 64'(exp_q.pop_front()));
        if (last_t >= 0) chk($sformatf("grant_spacing%0d", grants), 64'(i - last_t), 64'd4);
        last_t = i;
        grants++;
      end
      @(posedge clk); #1;
      if (gl) begin n_ls++; ls_req_valid[0] = (n_ls < 4); ls_addr[0] += 4; end
      if (gi) begin n_if++; if_req_valid[0] = (n_if < 4); if_addr[0] += 4; end
    end
    chk("grant_total", 64'(grants), 64'd8);
    clear_inputs();
    repeat (6) @(negedge clk);

    // Reset during WAIT of an LSU read (latency-3 instance).
    @(posedge clk); #1;
    ls_req_valid[1] = 1'b1; ls_addr[1] = 32'h0000_0200; ls_we[1] = 1'b0;
    @(negedge clk);
    chk("abort_accept", 64'(ls_req_ready[1]), 64'd1);
    @(posedge clk); #1;
    ls_req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_wait_busy", {62'd0, busy[1], owner[1]}, {62'd0, 1'b1, 1'b1});
    #2 rst[1] = 1'b1;
    #1;
    chk("abort_async", {60'd0, mem_en[1], busy[1], owner[1], ls_rsp_valid[1]}, 64'd0);
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", {62'd0, ls_rsp_valid[1], if_rsp_valid[1]}, 64'd0);
    end
    chk("abort_rdata_cleared", 64'(ls_rdata[1]), 64'd0);
    do_txn(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, dly, rd);
    chk("abort_next_latency", 64'(dly), 64'd5);
    chk("abort_next_rdata", 64'(rd), 64'hCAFE_F00D);

    // Reset during ACCESS drops the strobe at once and suppresses the write.
    @(posedge clk); #1;
    ls_req_valid[0] = 1'b1; ls_addr[0] = 32'h0000_0100; ls_wdata[0] = 32'h5555_AAAA; ls_we[0] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    ls_req_valid[0] = 1'b0;
    @(negedge clk);
    chk("access_strobe", {62'd0, mem_en[0], mem_we[0]}, 64'd3);
    #2 rst[0] = 1'b1;
    #1;
    chk("access_abort", {61'd0, mem_en[0], mem_we[0], busy[0]}, 64'd0);
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    do_txn(0, 1'b0, 1'b0, 32'h0000_0100, 32'h0, dly, rd);
    chk("access_abort_mem_kept", 64'(rd), 64'hDEAD_BEEF);

    // Randomized traffic on both instances against the transaction-level model.
    clear_inputs();
    pulse_reset();
    cyc = 0;
    model_init();
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      rand_drive(0);
      rand_drive(1);
      @(negedge clk);
      cyc++;
      model_step(0);
      model_step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
